// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared constants and encodings for the SCCB configuration sequencer
package sccb_pkg;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG = 8'hF0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WRITE,
        READ,
        COMPARE,
        DELAY,
        FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        START,
        WBYTE,
        RBYTE,
        STOP
    } phy_cmd_t;

    // Index of the last 4-quarter bit slot of each bus command; STOP carries
    // one extra idle bit so the bus rests a full bit time before any new start.
    function automatic logic [3:0] cmd_last_bit(input phy_cmd_t c);
        case (c)
            START:   return 4'd0;
            STOP:    return 4'd1;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/sccb_phy.sv
// rtl/sccb_phy.sv - SCCB quarter-tick generator and bit shifter
module sccb_phy
    import sccb_pkg::*;
#(
    parameter int QT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  phy_cmd_t   cmd,
    input  logic       cmd_valid,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic [7:0] rdata,
    output logic       sioc_oe,
    output logic       siod_oe,
    input  logic       siod_in
);

    localparam int CW = $clog2(QT);

    logic          active_q;
    phy_cmd_t      cmd_q;
    logic [7:0]    shift_q;
    logic [7:0]    rdata_q;
    logic [3:0]    bit_q;
    logic [1:0]    qtr_q;
    logic [CW-1:0] cnt_q;
    logic          sioc_q, sioc_d;
    logic          siod_q, siod_d;
    logic          tick;

    assign tick    = active_q && (cnt_q == CW'(QT - 1));
    assign ready   = ~active_q;
    assign rdata   = rdata_q;
    assign sioc_oe = sioc_q;
    assign siod_oe = siod_q;

    // Pin drive for the current quarter; pins hold their level between commands.
    always_comb begin
        sioc_d = sioc_q;
        siod_d = siod_q;
        if (active_q) begin
            case (cmd_q)
                START: begin
                    sioc_d = (qtr_q == 2'd3);
                    siod_d = (qtr_q != 2'd0);
                end
                WBYTE: begin
                    sioc_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                    siod_d = (bit_q < 4'd8) && !shift_q[7];
                end
                RBYTE: begin
                    sioc_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                    siod_d = 1'b0;
                end
                default: begin
                    sioc_d = (bit_q == 4'd0) && (qtr_q == 2'd0);
                    siod_d = (bit_q == 4'd0) && (qtr_q < 2'd2);
                end
            endcase
        end
    end

    // Command acceptance, quarter/bit sequencing, shifting and read sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            cmd_q    <= START;
            shift_q  <= '0;
            rdata_q  <= '0;
            bit_q    <= '0;
            qtr_q    <= '0;
            cnt_q    <= '0;
            sioc_q   <= 1'b0;
            siod_q   <= 1'b0;
        end else begin
            sioc_q <= sioc_d;
            siod_q <= siod_d;
            if (!active_q) begin
                if (cmd_valid) begin
                    active_q <= 1'b1;
                    cmd_q    <= cmd;
                    shift_q  <= wdata;
                    bit_q    <= '0;
                    qtr_q    <= '0;
                    cnt_q    <= '0;
                end
            end else if (tick) begin
                cnt_q <= '0;
                if (qtr_q == 2'd2 && cmd_q == RBYTE && bit_q < 4'd8) begin
                    rdata_q <= {rdata_q[6:0], siod_in};
                end
                if (qtr_q == 2'd3) begin
                    qtr_q <= '0;
                    if (bit_q == cmd_last_bit(cmd_q)) begin
                        active_q <= 1'b0;
                    end else begin
                        bit_q   <= bit_q + 4'd1;
                        shift_q <= {shift_q[6:0], 1'b0};
                    end
                end else begin
                    qtr_q <= qtr_q + 2'd1;
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sccb_config_seq.sv
// rtl/sccb_config_seq.sv - ROM-driven SCCB sensor configuration sequencer with readback verify
module sccb_config_seq
    import sccb_pkg::*;
#(
    parameter int          CLK_FREQ  = 100_000_000,
    parameter int          SCCB_FREQ = 100_000,
    parameter int          ROM_AW    = 8,
    parameter logic [7:0]  DEV_ID    = 8'h42,
    parameter int          VERIFY    = 1,
    parameter int          MAX_RETRY = 3,
    parameter int          XCLK_DIV  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sioc_oe,
    output logic              siod_oe,
    input  logic              siod_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_addr,
    output logic              x_clock
);

    localparam int QT       = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int MS_TICKS = CLK_FREQ / 1000;
    localparam int MSW      = $clog2(MS_TICKS + 1);
    localparam int RW       = $clog2(MAX_RETRY + 2);
    localparam int XW       = $clog2(XCLK_DIV / 2 + 1);

    seq_state_t        state_q, state_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [3:0]        step_q, step_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        val_q, val_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [7:0]        ms_left_q, ms_left_d;
    logic [MSW-1:0]    ms_cnt_q, ms_cnt_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ROM_AW-1:0] err_addr_q, err_addr_d;
    logic              start_q;
    logic [XW-1:0]     xcnt_q;
    logic              xclk_q;
    logic              start_edge;
    logic              advance;

    phy_cmd_t          phy_cmd;
    logic              phy_valid;
    logic [7:0]        phy_wdata;
    logic              phy_ready;
    logic [7:0]        phy_rdata;

    assign start_edge = start & ~start_q;
    assign busy       = (state_q != IDLE) && (state_q != FINISH);
    assign rom_addr   = addr_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_addr   = err_addr_q;
    assign x_clock    = xclk_q;

    sccb_phy #(
        .QT (QT)
    ) u_phy (
        .clk       (clk),
        .reset     (reset),
        .cmd       (phy_cmd),
        .cmd_valid (phy_valid),
        .wdata     (phy_wdata),
        .ready     (phy_ready),
        .rdata     (phy_rdata),
        .sioc_oe   (sioc_oe),
        .siod_oe   (siod_oe),
        .siod_in   (siod_in)
    );

    // Sequencer next-state: ROM walk, bus command issue, verify/retry and delays.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        step_d     = step_q;
        reg_d      = reg_q;
        val_d      = val_q;
        retry_d    = retry_q;
        ms_left_d  = ms_left_q;
        ms_cnt_d   = ms_cnt_q;
        done_d     = done_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        phy_valid  = 1'b0;
        phy_cmd    = START;
        phy_wdata  = DEV_ID;
        advance    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d    = FETCH;
                    addr_d     = '0;
                    retry_d    = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                reg_d = rom_data[15:8];
                val_d = rom_data[7:0];
                if (rom_data == ROM_END) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else if (rom_data[15:8] == DELAY_TAG) begin
                    state_d   = DELAY;
                    ms_left_d = rom_data[7:0];
                    ms_cnt_d  = '0;
                end else begin
                    state_d = WRITE;
                    step_d  = '0;
                end
            end
            WRITE: begin
                if (step_q < 4'd5) begin
                    phy_valid = 1'b1;
                    case (step_q)
                        4'd0:    phy_cmd = START;
                        4'd1:    begin phy_cmd = WBYTE; phy_wdata = DEV_ID; end
                        4'd2:    begin phy_cmd = WBYTE; phy_wdata = reg_q;  end
                        4'd3:    begin phy_cmd = WBYTE; phy_wdata = val_q;  end
                        default: phy_cmd = STOP;
                    endcase
                    if (phy_ready) step_d = step_q + 4'd1;
                end else if (phy_ready) begin
                    step_d = '0;
                    if (VERIFY != 0) state_d = READ;
                    else             advance = 1'b1;
                end
            end
            READ: begin
                if (step_q < 4'd8) begin
                    phy_valid = 1'b1;
                    case (step_q)
                        4'd0:    phy_cmd = START;
                        4'd1:    begin phy_cmd = WBYTE; phy_wdata = DEV_ID; end
                        4'd2:    begin phy_cmd = WBYTE; phy_wdata = reg_q;  end
                        4'd3:    phy_cmd = STOP;
                        4'd4:    phy_cmd = START;
                        4'd5:    begin phy_cmd = WBYTE; phy_wdata = DEV_ID | 8'h01; end
                        4'd6:    phy_cmd = RBYTE;
                        default: phy_cmd = STOP;
                    endcase
                    if (phy_ready) step_d = step_q + 4'd1;
                end else if (phy_ready) begin
                    step_d  = '0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (phy_rdata == val_q) begin
                    advance = 1'b1;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    step_d  = '0;
                    state_d = WRITE;
                end else begin
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                    done_d     = 1'b1;
                    state_d    = FINISH;
                end
            end
            DELAY: begin
                if (ms_left_q == 8'd0) begin
                    advance = 1'b1;
                end else if (ms_cnt_q == MSW'(MS_TICKS - 1)) begin
                    ms_cnt_d  = '0;
                    ms_left_d = ms_left_q - 8'd1;
                end else begin
                    ms_cnt_d = ms_cnt_q + MSW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Moving past the last ROM slot ends the pass cleanly, as if an end marker was read.
        if (advance) begin
            retry_d = '0;
            if (addr_q == '1) begin
                state_d = FINISH;
                done_d  = 1'b1;
            end else begin
                addr_d  = addr_q + ROM_AW'(1);
                state_d = FETCH;
            end
        end
    end

    // Sequencer state register; start_q resets high so a start held through reset is not a launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            step_q     <= '0;
            reg_q      <= '0;
            val_q      <= '0;
            retry_q    <= '0;
            ms_left_q  <= '0;
            ms_cnt_q   <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            start_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            step_q     <= step_d;
            reg_q      <= reg_d;
            val_q      <= val_d;
            retry_q    <= retry_d;
            ms_left_q  <= ms_left_d;
            ms_cnt_q   <= ms_cnt_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
            start_q    <= start;
        end
    end

    // Sensor XCLK: toggle every XCLK_DIV/2 clocks for a 50% duty square wave.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xcnt_q <= '0;
            xclk_q <= 1'b0;
        end else if (xcnt_q == XW'(XCLK_DIV / 2 - 1)) begin
            xcnt_q <= '0;
            xclk_q <= ~xclk_q;
        end else begin
            xcnt_q <= xcnt_q + XW'(1);
        end
    end

endmodule
